seq_multdiv: RTL and testbench
==============================

// Module: seq_multdiv
// PURPOSE
//  Sequential signed 32-bit multiplier/divider. Responds to the pipeline's one-cycle
//  ctrl_MULT/ctrl_DIV start pulses issued from the execute stage.
//  Returns a single-cycle data_resultRDY pulse with the result and exception flag.
//  Holds no architectural state; the pipeline stalls on busy and writes the result back itself.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; iteration count equals WIDTH
// PORTS
//  clock           in   1      rising-edge clock, the single clock domain
//  reset           in   1      asynchronous, active-high; clears all state
//  ctrl_MULT       in   1      start-multiply pulse, sampled on the rising edge
//  ctrl_DIV        in   1      start-divide pulse, sampled on the rising edge
//  data_operandA   in   WIDTH  multiplicand / dividend (two's complement)
//  data_operandB   in   WIDTH  multiplier / divisor (two's complement)
//  data_result     out  WIDTH  low WIDTH bits of product, or quotient
//  data_exception  out  1      overflow / divide-by-zero flag, qualified by data_resultRDY
//  data_resultRDY  out  1      one-cycle pulse: result and exception valid
//  busy            out  1      high while an operation is in flight (RUN states)
// BEHAVIOUR
//  Reset: state=IDLE, count=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
//  Operand capture: operands are latched on the edge where a ctrl pulse is seen.
//   Operands need not be held afterwards.
//  FSM states and transitions:
//   IDLE    -> MUL_RUN on ctrl_MULT; -> DIV_RUN on ctrl_DIV
//   MUL_RUN -> DONE when count==WIDTH-1
//   DIV_RUN -> DONE when count==WIDTH-1
//   DONE    -> IDLE
//  count increments once per RUN cycle.
//  Latency is fixed. For a ctrl pulse captured at edge k, data_resultRDY is high in the
//   cycle after edge k+WIDTH+1, for exactly one cycle (WIDTH=32: 33 edges after capture).
//   Latency is identical for MUL, DIV and every exception case.
//  data_result/data_exception update together with RDY.
//   They hold their value until the next RDY; the bench checks them only while RDY=1.
//  Multiply: radix-2 Booth over a 2*WIDTH+1 product register.
//   data_result = product[WIDTH-1:0].
//   exception=1 iff the full 2*WIDTH signed product is not the sign-extension of its low WIDTH bits.
//  Divide: operands are made non-negative, then a WIDTH-step restoring divide runs.
//   The quotient is negated if the operand signs differ (truncation toward zero). Remainder is discarded.
//  Divide by zero (B==0): result=0, exception=1.
//  Signed overflow (A==min negative, B==-1): result=min negative (0x80000000), exception=1.
//  Simultaneous ctrl_MULT & ctrl_DIV: multiply wins; the divide request is dropped.
//  ctrl pulse while busy: the current operation is abandoned with no RDY for it.
//   The new operands are latched, count=0, and latency restarts from that edge.
//  A ctrl pulse in DONE is accepted the same way (RDY for the old op still fires that cycle).
//  Reset mid-operation returns to IDLE immediately and asynchronously; no RDY pulse follows.
//  busy=1 in MUL_RUN/DIV_RUN, 0 in IDLE/DONE.
// TESTING
//  1. MULT 7 x -3 -> RDY exactly 33 edges after the pulse, result=-21 (0xFFFFFFEB), exc=0.
//  2. MULT 0x40000000 x 4 -> result=0x00000000, exc=1.
//     Also MULT 0x80000000 x 1 -> result=0x80000000, exc=0.
//  3. DIV -7 / 2 -> result=-3.
//     Also DIV 100 / -7 -> result=-14; DIV 0x7FFFFFFF / 1 -> 0x7FFFFFFF, exc=0.
//  4. DIV 5 / 0 -> result=0, exc=1 at the same 33-edge latency.
//     Also DIV 0x80000000 / -1 -> result=0x80000000, exc=1.
//  5. MULT 3x3, then DIV 9/3 pulsed 10 edges later -> one RDY only, result=3.
//     The RDY lands 33 edges after the DIV pulse.
//  6. Assert reset 5 edges into MULT 6x7 -> outputs zero at once and no RDY within 40 edges.
//     A later MULT 6x7 then gives 42. Also pulse both ctrls together on 6,7 -> result=42.

Source files
------------

// File: rtl/seq_multdiv.sv
// Sequential signed multiplier/divider: radix-2 Booth multiply and restoring divide,
// one iteration per clock, fixed latency, single-cycle result pulse.
module seq_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshake: ctrl_MULT/ctrl_DIV are accepted on any edge (a new request replaces
  // any op in flight); data_resultRDY is a one-cycle valid with no ready/back-pressure.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH:0]     prod_q, prod_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 neg_q, neg_d;
  logic                 dz_q, dz_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;

  // Booth step: the accumulator gets one guard bit so that subtracting the most
  // negative multiplicand cannot wrap.
  logic [WIDTH:0]       hi_ext, a_ext, booth_sum;
  logic [2*WIDTH:0]     prod_step;
  logic [2*WIDTH-1:0]   full_prod;
  logic [WIDTH+1:0]     rs, dv;
  logic                 ge;
  logic [WIDTH-1:0]     abs_a, abs_b, quo_signed;

  always_comb begin
    hi_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    a_ext  = {a_q[WIDTH-1], a_q};
    case (prod_q[1:0])
      2'b01:   booth_sum = hi_ext + a_ext;
      2'b10:   booth_sum = hi_ext - a_ext;
      default: booth_sum = hi_ext;
    endcase
    prod_step  = {booth_sum, prod_q[WIDTH:1]};
    full_prod  = prod_q[2*WIDTH:1];

    rs         = {rem_q, quo_q[WIDTH-1]};
    dv         = {2'b00, dvs_q};
    ge         = (rs >= dv);

    abs_a      = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    abs_b      = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    quo_signed = neg_q ? (~quo_q + 1'b1) : quo_q;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    case (state_q)
      MUL_RUN: begin
        prod_d  = prod_step;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          count_d = '0;
        end
      end
      DIV_RUN: begin
        rem_d   = ge ? (WIDTH+1)'(rs - dv) : (WIDTH+1)'(rs);
        quo_d   = {quo_q[WIDTH-2:0], ge};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          count_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        if (dz_q) begin
          result_d = '0;
          exc_d    = 1'b1;
        end else if (neg_q || quo_q != '0 || dvs_q != '0) begin
          result_d = quo_signed;
          exc_d    = ovf_q;
        end
        // A multiply leaves dvs_q cleared and dz_q low; its result overrides below.
        if (dvs_q == '0 && !dz_q) begin
          result_d = full_prod[WIDTH-1:0];
          exc_d    = (full_prod[2*WIDTH-1:WIDTH] != {WIDTH{full_prod[WIDTH-1]}});
        end
      end
      default: ;
    endcase

    // A new request always wins, including in DONE where the old RDY still fires.
    if (ctrl_MULT || ctrl_DIV) begin
      count_d = '0;
      if (ctrl_MULT) begin
        state_d = MUL_RUN;
        a_d     = data_operandA;
        prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
        dvs_d   = '0;
        dz_d    = 1'b0;
        ovf_d   = 1'b0;
        neg_d   = 1'b0;
        quo_d   = '0;
        rem_d   = '0;
      end else begin
        state_d = DIV_RUN;
        rem_d   = '0;
        quo_d   = abs_a;
        dvs_d   = abs_b;
        neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_d    = (data_operandB == '0);
        ovf_d   = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == MUL_RUN) || (state_q == DIV_RUN);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_seq_multdiv.sv
// Directed self-checking bench for seq_multdiv: latency, multiply/divide results,
// exception cases, request pre-emption and asynchronous reset.
module tb_seq_multdiv;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrl_MULT, ctrl_DIV;
  logic [W-1:0] opa, opb;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multdiv #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (opa),
    .data_operandB (opb),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  // Pulses a request for one edge, then scrambles the operand bus.
  task automatic start_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; opa = a; opb = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    opa = $urandom; opb = $urandom;
  endtask

  // Returns edges from capture to the first RDY (or -1 after a 40-edge budget).
  task automatic wait_rdy(output int lat, output logic [W-1:0] res, output logic exc);
    lat = -1; res = 'x; exc = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        lat = n; res = data_result; exc = data_exception;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; opa = '0; opb = '0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h exp %h", data_result, 32'h0); end
    n_checks++; if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b exp 0", data_exception); end
    n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b exp 0", data_resultRDY); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_mult_basic();
    int lat; logic [W-1:0] res; logic exc;
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %b exp 1", busy); end
    wait_rdy(lat, res, exc);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d exp 33", lat); end
    n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_7x-3: got %h exp ffffffeb", res); end
    n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL mul_7x-3_exc: got %b exp 0", exc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_at_rdy: got %b exp 0", busy); end
    @(posedge clock); #1;
    n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL mul_rdy_width: got %b exp 0", data_resultRDY); end
  endtask

  task automatic test_mult_overflow();
    int lat; logic [W-1:0] res; logic exc;
    start_op(1'b1, 1'b0, 32'h4000_0000, 32'd4);
    wait_rdy(lat, res, exc);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL mul_ovf_result: got %h exp 00000000", res); end
    n_checks++; if (exc !== 1'b1) begin n_fail++; $display("FAIL mul_ovf_exc: got %b exp 1", exc); end
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'd1);
    wait_rdy(lat, res, exc);
    n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL mul_min_x1: got %h exp 80000000", res); end
    n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL mul_min_x1_exc: got %b exp 0", exc); end
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_rdy(lat, res, exc);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL mul_min_x_min: got %h exp 00000000", res); end
    n_checks++; if (exc !== 1'b1) begin n_fail++; $display("FAIL mul_min_x_min_exc: got %b exp 1", exc); end
  endtask

  task automatic test_div();
    int lat; logic [W-1:0] res; logic exc;
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_rdy(lat, res, exc);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d exp 33", lat); end
    n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_-7/2: got %h exp fffffffd", res); end
    n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL div_-7/2_exc: got %b exp 0", exc); end
    start_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    wait_rdy(lat, res, exc);
    n_checks++; if (res !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL div_100/-7: got %h exp fffffff2", res); end
    start_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1);
    wait_rdy(lat, res, exc);
    n_checks++; if (res !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL div_max/1: got %h exp 7fffffff", res); end
    n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL div_max/1_exc: got %b exp 0", exc); end
    start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    wait_rdy(lat, res, exc);
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL div_-100/-7: got %h exp 0000000e", res); end
  endtask

  task automatic test_div_exceptions();
    int lat; logic [W-1:0] res; logic exc;
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    wait_rdy(lat, res, exc);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divz_latency: got %0d exp 33", lat); end
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL divz_result: got %h exp 00000000", res); end
    n_checks++; if (exc !== 1'b1) begin n_fail++; $display("FAIL divz_exc: got %b exp 1", exc); end
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy(lat, res, exc);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divovf_latency: got %0d exp 33", lat); end
    n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_result: got %h exp 80000000", res); end
    n_checks++; if (exc !== 1'b1) begin n_fail++; $display("FAIL divovf_exc: got %b exp 1", exc); end
  endtask

  task automatic test_back_to_back();
    int rdy_cnt = 0; int lat = -1; logic [W-1:0] res = 'x; logic exc = 1'bx;
    start_op(1'b1, 1'b0, 32'd3, 32'd3);
    for (int n = 0; n < 9; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_cnt++;
    end
    start_op(1'b0, 1'b1, 32'd9, 32'd3);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (lat < 0) begin lat = n; res = data_result; exc = data_exception; end
      end
    end
    n_checks++; if (rdy_cnt !== 1) begin n_fail++; $display("FAIL b2b_rdy_count: got %0d exp 1", rdy_cnt); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d exp 33", lat); end
    n_checks++; if (res !== 32'd3) begin n_fail++; $display("FAIL b2b_result: got %h exp 00000003", res); end
    n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL b2b_exc: got %b exp 0", exc); end
  endtask

  task automatic test_reset_mid_op();
    int rdy_cnt = 0; int lat; logic [W-1:0] res; logic exc;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (data_result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h exp 00000000", data_result); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d exp 0", dbg_state); end
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_cnt++;
    end
    n_checks++; if (rdy_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_rdy: got %0d exp 0", rdy_cnt); end
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    wait_rdy(lat, res, exc);
    n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL rst_then_mul: got %h exp 0000002a", res); end
    start_op(1'b1, 1'b1, 32'd6, 32'd7);
    wait_rdy(lat, res, exc);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL both_ctrl_latency: got %0d exp 33", lat); end
    n_checks++; if (res !== 32'd42) begin n_fail++; $display("FAIL both_ctrl_result: got %h exp 0000002a", res); end
    n_checks++; if (exc !== 1'b0) begin n_fail++; $display("FAIL both_ctrl_exc: got %b exp 0", exc); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult_basic();
    test_mult_overflow();
    test_div();
    test_div_exceptions();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
